// File: rtl/line_burst_memory_interface.sv
// Bridge between the last-level cache and main memory: moves one cache line as a
// burst of beats, optionally critical-word-first for reads, with a one-cycle response.
module line_burst_memory_interface #(
    parameter int STATUS_BITS         = 3,
    parameter int COHERENCE_BITS      = 2,
    parameter int OFFSET_BITS         = 2,
    parameter int BEAT_BITS           = 0,
    parameter int DATA_WIDTH          = 8,
    parameter int ADDRESS_WIDTH       = 12,
    parameter int MSG_BITS            = 3,
    parameter int CRITICAL_WORD_FIRST = 1,
    localparam int WPL  = 1 << OFFSET_BITS,
    localparam int BW   = DATA_WIDTH << BEAT_BITS,
    localparam int LINE = STATUS_BITS + COHERENCE_BITS + DATA_WIDTH * WPL
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [MSG_BITS-1:0]      cache2interface_msg,
    input  logic [ADDRESS_WIDTH-1:0] cache2interface_address,
    input  logic [LINE-1:0]          cache2interface_data,
    output logic [MSG_BITS-1:0]      interface2cache_msg,
    output logic [ADDRESS_WIDTH-1:0] interface2cache_address,
    output logic [LINE-1:0]          interface2cache_data,
    output logic [MSG_BITS-1:0]      interface2mem_msg,
    output logic [ADDRESS_WIDTH-1:0] interface2mem_address,
    output logic [BW-1:0]            interface2mem_data,
    input  logic [MSG_BITS-1:0]      mem2interface_msg,
    input  logic [ADDRESS_WIDTH-1:0] mem2interface_address,
    input  logic [BW-1:0]            mem2interface_data,
    output logic                     busy
);

    // state   | meaning
    // IDLE    | waiting for a cache request
    // READ    | fetching beats from memory, possibly wrapping from the critical beat
    // WRITE   | sending latched line beats 0..BEATS-1 to memory
    // RESPOND | one-cycle response to the cache

    localparam int BEATS   = WPL >> BEAT_BITS;
    localparam int WORDS_W = DATA_WIDTH * WPL;
    localparam int CW      = OFFSET_BITS - BEAT_BITS + 1;
    localparam int TOP_W   = STATUS_BITS + COHERENCE_BITS;

    localparam logic [MSG_BITS-1:0] NO_REQ     = MSG_BITS'(0);
    localparam logic [MSG_BITS-1:0] WB_REQ     = MSG_BITS'(1);
    localparam logic [MSG_BITS-1:0] R_REQ      = MSG_BITS'(2);
    localparam logic [MSG_BITS-1:0] FLUSH      = MSG_BITS'(3);
    localparam logic [MSG_BITS-1:0] INVLD      = MSG_BITS'(4);
    localparam logic [MSG_BITS-1:0] MEM_NO_MSG = MSG_BITS'(0);
    localparam logic [MSG_BITS-1:0] MEM_READY  = MSG_BITS'(1);
    localparam logic [MSG_BITS-1:0] MEM_SENT   = MSG_BITS'(2);
    localparam logic [MSG_BITS-1:0] M_RECV     = MSG_BITS'(3);

    localparam logic [WORDS_W-1:0] BEAT_MASK = WORDS_W'({BW{1'b1}});

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [MSG_BITS-1:0]      resp_q;
    logic [WORDS_W-1:0]       line_q;
    logic                     valid_q;
    logic [CW-1:0]            beat_idx_q;
    logic [CW-1:0]            beats_left_q;

    logic                     req_flush;
    logic                     req_dirty;
    logic                     take_read;
    logic                     take_write;
    logic                     take_clean;
    logic                     accept;
    logic                     mem_ack;
    logic                     last_beat;
    logic [CW-1:0]            start_beat;
    logic [CW-1:0]            next_idx;
    logic [31:0]              beat_lsb;
    logic [ADDRESS_WIDTH-1:0] beat_addr;
    logic [MSG_BITS-1:0]      accept_resp;
    logic                     unused_inputs;

    // Request decode; only meaningful while IDLE
    assign req_flush  = (cache2interface_msg == FLUSH) || (cache2interface_msg == INVLD);
    assign req_dirty  = cache2interface_data[LINE-2];
    assign take_read  = (cache2interface_msg == R_REQ);
    assign take_write = !take_read &&
                        ((cache2interface_msg == WB_REQ) || (req_flush && req_dirty));
    assign take_clean = !take_read && req_flush && !req_dirty;
    assign accept     = (state_q == IDLE) && (take_read || take_write || take_clean);

    assign accept_resp = take_read                       ? MEM_SENT  :
                         (cache2interface_msg == WB_REQ) ? MEM_READY : M_RECV;

    assign start_beat = (CRITICAL_WORD_FIRST != 0)
                      ? CW'((cache2interface_address >> BEAT_BITS) & ADDRESS_WIDTH'(BEATS - 1))
                      : '0;

    assign mem_ack   = ((state_q == READ)  && (mem2interface_msg == MEM_SENT)) ||
                       ((state_q == WRITE) && (mem2interface_msg == MEM_READY));
    assign last_beat = (beats_left_q == CW'(1));
    assign next_idx  = (beat_idx_q == CW'(BEATS - 1)) ? '0 : beat_idx_q + CW'(1);

    assign beat_lsb  = 32'(beat_idx_q) * 32'(BW);
    assign beat_addr = (addr_q & ~ADDRESS_WIDTH'(WPL - 1)) +
                       (ADDRESS_WIDTH'(beat_idx_q) << BEAT_BITS);

    assign interface2cache_data = {valid_q, {(TOP_W-1){1'b0}}, line_q};

    assign unused_inputs = ^{mem2interface_address, cache2interface_data};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take_read) begin
                    state_d = READ;
                end else if (take_write) begin
                    state_d = WRITE;
                end else if (take_clean) begin
                    state_d = RESPOND;
                end
            end
            READ, WRITE: begin
                if (mem_ack && last_beat) begin
                    state_d = RESPOND;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        interface2cache_msg     = MEM_NO_MSG;
        interface2cache_address = '0;
        interface2mem_msg       = NO_REQ;
        interface2mem_address   = '0;
        interface2mem_data      = '0;
        busy                    = (state_q != IDLE);
        case (state_q)
            READ: begin
                interface2mem_msg     = R_REQ;
                interface2mem_address = beat_addr;
            end
            WRITE: begin
                interface2mem_msg     = WB_REQ;
                interface2mem_address = beat_addr;
                interface2mem_data    = BW'(line_q >> beat_lsb);
            end
            RESPOND: begin
                interface2cache_msg     = resp_q;
                interface2cache_address = addr_q;
            end
            default: ;
        endcase
    end

    // The whole line is captured at acceptance so the cache may move on immediately
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q       <= '0;
            resp_q       <= MEM_NO_MSG;
            line_q       <= '0;
            valid_q      <= 1'b0;
            beat_idx_q   <= '0;
            beats_left_q <= '0;
        end else if (accept) begin
            addr_q       <= cache2interface_address;
            resp_q       <= accept_resp;
            line_q       <= cache2interface_data[WORDS_W-1:0];
            valid_q      <= 1'b1;
            beat_idx_q   <= take_read ? start_beat : '0;
            beats_left_q <= CW'(BEATS);
        end else if (mem_ack) begin
            if (state_q == READ) begin
                line_q <= (line_q & ~(BEAT_MASK << beat_lsb)) |
                          (WORDS_W'(mem2interface_data) << beat_lsb);
            end
            beat_idx_q   <= next_idx;
            beats_left_q <= beats_left_q - CW'(1);
        end
    end

endmodule
